jpeg_bitwin: RTL and testbench



---
 rtl/jpeg_pkg.sv | 20 ++
 rtl/jpeg_byte_unstuff.sv | 33 +++
 rtl/jpeg_bitwin.sv | 100 ++++++++++
 tb/tb_jpeg_bitwin.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG bit-window path: buffer/window defaults,
// marker byte values and the top-level state codes used by the pc-delta logic.
package jpeg_pkg;

   localparam int BUF_W_DFLT = 128;
   localparam int WIN_W_DFLT = 64;

   localparam logic [7:0] MRK_FF  = 8'hFF;
   localparam logic [7:0] MRK_SOI = 8'hD8;
   localparam logic [7:0] MRK_EOI = 8'hD9;
   localparam logic [7:0] MRK_SOS = 8'hDA;

   typedef enum logic [1:0] {
      STATE_FILL  = 2'd0,
      STATE_RUN   = 2'd1,
      STATE_DRAIN = 2'd2,
      STATE_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/jpeg_byte_unstuff.sv
// Byte-stuffing filter: drops the 0x00 that follows an appended 0xFF inside
// an entropy-coded segment. Only instantiated when JPEG_UNSTUFF_EN is defined.
module jpeg_byte_unstuff
   import jpeg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_in,
   input  logic       byte_fire,
   input  logic       scan_mode,
   input  logic       flush,
   output logic       keep
);

   logic prev_ff_q, prev_ff_d;

   always_comb begin
      keep      = !(scan_mode && prev_ff_q && (byte_in == 8'h00));
      prev_ff_d = prev_ff_q;
      if (flush || !scan_mode) begin
         prev_ff_d = 1'b0;
      end else if (byte_fire) begin
         // a dropped stuffing byte also clears the flag (keep is 0 then)
         prev_ff_d = keep && (byte_in == MRK_FF);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_ff_q <= 1'b0;
      else      prev_ff_q <= prev_ff_d;
   end

endmodule

// File: rtl/jpeg_bitwin.sv
// Bit-window controller: byte-wide stream in, MSB-first shift buffer, 64-bit
// look-ahead window out. Optional byte unstuffing under JPEG_UNSTUFF_EN.
module jpeg_bitwin
   import jpeg_pkg::*;
#(
   parameter int BUF_W = BUF_W_DFLT,
   parameter int WIN_W = WIN_W_DFLT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   input  logic             scan_mode,
   input  logic             flush,
   input  logic [7:0]       pc_delta,
   output logic             bit_avali,
   output logic [WIN_W-1:0] window,
   output logic [7:0]       fill,
   output logic             proto_err
);

   logic [BUF_W-1:0] buf_q, buf_d;
   logic [BUF_W-1:0] byte_ext;
   logic [7:0]       fill_q, fill_d;
   logic             eos_q, eos_d;
   logic             perr_q, perr_d;
   logic [7:0]       d_bits;
   logic [7:0]       surv;
   logic [7:0]       ins_sh;
   logic             fire;
   logic             keep;
   logic             append;

   assign in_ready  = !eos_q && (fill_q <= 8'(BUF_W - 8));
   assign bit_avali = (fill_q >= 8'(WIN_W)) || (eos_q && (fill_q != 8'd0));
   assign window    = buf_q[BUF_W-1 -: WIN_W];
   assign fill      = fill_q;
   assign proto_err = perr_q;

   assign fire   = in_valid && in_ready && !flush;
   assign append = fire && keep;

`ifdef JPEG_UNSTUFF_EN
   jpeg_byte_unstuff u_unstuff (
      .clk       (clk),
      .rst       (rst),
      .byte_in   (in_data),
      .byte_fire (fire),
      .scan_mode (scan_mode),
      .flush     (flush),
      .keep      (keep)
   );
`else
   logic unused_scan_mode;
   assign unused_scan_mode = scan_mode;
   assign keep             = 1'b1;
`endif

   always_comb begin
      d_bits = bit_avali ? pc_delta : 8'd0;
      perr_d = perr_q;
      if (d_bits > 8'(WIN_W)) begin
         d_bits = 8'(WIN_W);
         perr_d = 1'b1;
      end
      // drain tail: retire whatever is left, not an error
      if (d_bits > fill_q) d_bits = fill_q;

      surv     = fill_q - d_bits;
      ins_sh   = 8'(BUF_W - 8) - surv;
      byte_ext = BUF_W'(in_data) << ins_sh;
      buf_d    = (buf_q << d_bits) | (append ? byte_ext : '0);
      fill_d   = surv + (append ? 8'd8 : 8'd0);
      eos_d    = eos_q || (fire && in_last);

      if (flush) begin
         buf_d  = '0;
         fill_d = 8'd0;
         eos_d  = 1'b0;
         perr_d = perr_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q  <= '0;
         fill_q <= 8'd0;
         eos_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         fill_q <= fill_d;
         eos_q  <= eos_d;
         perr_q <= perr_d;
      end
   end

endmodule

// File: tb/tb_jpeg_bitwin.sv
// Bench for jpeg_bitwin: directed scenarios then random traffic, all checked
// against a bit-queue model of the stream.
module tb_jpeg_bitwin;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic        scan_mode;
   logic        flush;
   logic [7:0]  pc_delta;
   logic        bit_avali;
   logic [63:0] window;
   logic [7:0]  fill;
   logic        proto_err;

   int errs   = 0;
   int checks = 0;

   bit mq[$];
   bit m_eos, m_perr, m_prevff;

   logic [7:0] rb, rd;
   logic       rv, rl, rf;
   logic       rscan = 1'b0;

   always #5 clk = ~clk;

   jpeg_bitwin dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .scan_mode (scan_mode),
      .flush     (flush),
      .pc_delta  (pc_delta),
      .bit_avali (bit_avali),
      .window    (window),
      .fill      (fill),
      .proto_err (proto_err)
   );

   function automatic logic [63:0] m_window();
      logic [63:0] w = '0;
      for (int i = 0; i < 64; i++)
         if (i < mq.size()) w[63-i] = mq[i];
      return w;
   endfunction

   function automatic logic m_ready();
      return !m_eos && (mq.size() <= 120);
   endfunction

   function automatic logic m_avali();
      return (mq.size() >= 64) || (m_eos && mq.size() != 0);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("fill",      64'(fill),      64'(mq.size()));
      chk("window",    window,         m_window());
      chk("in_ready",  64'(in_ready),  64'(m_ready()));
      chk("bit_avali", 64'(bit_avali), 64'(m_avali()));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
   endtask

   task automatic model_clear();
      mq.delete();
      m_eos    = 1'b0;
      m_prevff = 1'b0;
   endtask

   // One clock cycle: compare at the negedge, drive, advance the model.
   task automatic cyc(input logic v, input logic [7:0] b, input logic last,
                      input logic [7:0] dl, input logic fl, input logic sc);
      int  d;
      bit  fire, keep;
      check_state();
      in_valid  = v;
      in_data   = b;
      in_last   = last;
      pc_delta  = dl;
      flush     = fl;
      scan_mode = sc;
      if (fl) begin
         model_clear();
      end else begin
         fire = v && m_ready();
         d = m_avali() ? int'(dl) : 0;
         if (d > 64) begin
            d = 64;
            m_perr = 1'b1;
         end
         if (d > mq.size()) d = mq.size();
         for (int i = 0; i < d; i++) void'(mq.pop_front());
         keep = 1'b1;
`ifdef JPEG_UNSTUFF_EN
         keep = !(sc && m_prevff && b == 8'h00);
         if (!sc) m_prevff = 1'b0;
         else if (fire) m_prevff = keep && (b == 8'hFF);
`endif
         if (fire && keep)
            for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
         if (fire && last) m_eos = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      pc_delta = 8'd0;
      flush    = 1'b0;
   endtask

   task automatic feed(input logic [7:0] b);
      cyc(1'b1, b, 1'b0, 8'd0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [63:0] hdr;
      rst       = 1'b0;
      in_data   = 8'd0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      scan_mode = 1'b0;
      flush     = 1'b0;
      pc_delta  = 8'd0;
      m_perr    = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      chk("rst_ready",  64'(in_ready),  64'd1);
      chk("rst_avali",  64'(bit_avali), 64'd0);
      chk("rst_window", window,         64'd0);
      check_state();
      rst = 1'b1;

      hdr = 64'hFFD8FFDB00430008;
      for (int i = 7; i >= 0; i--) begin
         chk("hdr_ready", 64'(in_ready), 64'd1);
         feed(hdr[i*8 +: 8]);
      end
      chk("hdr_fill",   64'(fill),      64'd64);
      chk("hdr_avali",  64'(bit_avali), 64'd1);
      chk("hdr_window", window,         64'hFFD8FFDB00430008);

      cyc(1'b1, 8'h11, 1'b0, 8'd16, 1'b0, 1'b0);
      chk("mix_fill",   64'(fill),      64'd56);
      chk("mix_window", window,         64'hFFDB004300081100);
      chk("mix_avali",  64'(bit_avali), 64'd0);

      for (int i = 0; i < 9; i++) feed(8'(8'hA0 + i));
      chk("full_fill",  64'(fill),     64'd128);
      chk("full_ready", 64'(in_ready), 64'd0);
      cyc(1'b0, 8'h00, 1'b0, 8'd8, 1'b0, 1'b0);
      chk("pop8_ready", 64'(in_ready), 64'd1);
      chk("pop8_fill",  64'(fill),     64'd120);

      cyc(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) feed(8'(8'h30 + i));
      cyc(1'b0, 8'h00, 1'b0, 8'd80, 1'b0, 1'b0);
      chk("clamp_fill", 64'(fill),      64'd0);
      chk("clamp_err",  64'(proto_err), 64'd1);
      cyc(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0);
      chk("err_sticky", 64'(proto_err), 64'd1);

      feed(8'hAB);
      feed(8'hCD);
      cyc(1'b1, 8'hEF, 1'b1, 8'd0, 1'b0, 1'b0);
      chk("eos_fill",   64'(fill),      64'd24);
      chk("eos_avali",  64'(bit_avali), 64'd1);
      chk("eos_window", window,         64'hABCDEF0000000000);
      chk("eos_ready",  64'(in_ready),  64'd0);
      cyc(1'b0, 8'h00, 1'b0, 8'd32, 1'b0, 1'b0);
      chk("drain_fill",  64'(fill),      64'd0);
      chk("drain_avali", 64'(bit_avali), 64'd0);

      cyc(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b1);
      cyc(1'b1, 8'h12, 1'b0, 8'd0, 1'b0, 1'b1);
      cyc(1'b1, 8'hFF, 1'b0, 8'd0, 1'b0, 1'b1);
      cyc(1'b1, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1);
      cyc(1'b1, 8'h34, 1'b0, 8'd0, 1'b0, 1'b1);
`ifdef JPEG_UNSTUFF_EN
      chk("stuff_fill", 64'(fill),          64'd24);
      chk("stuff_top",  64'(window[63:40]), 64'h12FF34);
`else
      chk("stuff_fill", 64'(fill),          64'd32);
      chk("stuff_top",  64'(window[63:32]), 64'h12FF0034);
`endif
      cyc(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0);
      feed(8'h12);
      feed(8'hFF);
      feed(8'h00);
      feed(8'h34);
      chk("raw_fill", 64'(fill), 64'd32);

      for (int i = 0; i < 800; i++) begin
         if (i == 400) begin
            #2 rst = 1'b0;
            #1;
            chk("async_fill",   64'(fill),     64'd0);
            chk("async_window", window,        64'd0);
            chk("async_ready",  64'(in_ready), 64'd1);
            chk("async_err",    64'(proto_err), 64'd0);
            model_clear();
            m_perr = 1'b0;
            @(negedge clk);
            rst = 1'b1;
         end
         rv = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       rb = 8'h00;
            1:       rb = 8'hFF;
            default: rb = 8'($urandom_range(0, 255));
         endcase
         rl = ($urandom_range(0, 79) == 0);
         rf = ($urandom_range(0, 49) == 0);
         rd = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(65, 255))
                                          : 8'($urandom_range(0, 64));
         if ($urandom_range(0, 19) == 0) rscan = ~rscan;
         cyc(rv, rb, rl, rd, rf, rscan);
      end
      check_state();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
